inst_fetch_unit: RTL and testbench
==================================

Name: inst_fetch_unit

Overview:
- Initiator side of the instruction-fetch interface.
- Owns the fetch program counter and drives inst_add into the integrated instruction memory, which returns inst_code combinationally in the same cycle.
- Captures each {pc, inst_code} pair into a small FIFO fetch queue and presents it to decode through a valid/ready handshake.
- Handles branch/jump redirects (queue flush), halt requests and misaligned-target detection.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- QUEUE_DEPTH, 2, fetch queue entries; power of 2, minimum 2.
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- reset, input, 1, synchronous active-low reset (reset==0 resets on the clock edge).
- inst_add, output, 32, fetch address to instruction memory; equals fetch_pc combinationally.
- inst_code, input, 32, instruction word returned by memory for inst_add in the same cycle.
- redirect_valid, input, 1, branch/jump taken this cycle.
- redirect_pc, input, 32, new fetch target; sampled when redirect_valid=1.
- halt_req, input, 1, level; stop issuing new fetches while high.
- out_valid, output, 1, queue head holds a valid instruction.
- out_inst, output, 32, instruction at queue head.
- out_pc, output, 32, address of out_inst.
- out_ready, input, 1, decode accepts head this cycle.
- fetch_misalign, output, 1, sticky error: redirect_pc[1:0] was nonzero.

Behaviour:
- Reset (reset==0 at an edge):
  - fetch_pc=RESET_PC, queue count=0, rd/wr pointers=0, state=IDLE.
  - out_valid=0, out_inst=0, out_pc=0, fetch_misalign=0.
  - Reset overrides every other input, including mid-operation; all queued entries are discarded.
- States:
  - IDLE: one cycle after reset release, no fetch; next state RUN.
  - RUN: normal fetching.
  - HALT: no fetch; the queue still drains to decode.
  - ERR: no fetch, no output; left only by reset.
- Transitions:
  - RUN->HALT when halt_req=1.
  - HALT->RUN when halt_req=0.
  - RUN or HALT -> ERR on redirect_valid=1 with redirect_pc[1:0]!=0: queue flushed, fetch_misalign<=1.
- Pop: when out_valid=1 and out_ready=1, the head is consumed at the edge.
- Fetch (push):
  - Occurs in RUN when halt_req=0, redirect_valid=0, and (count<QUEUE_DEPTH or pop this cycle).
  - Enqueues {inst_add, inst_code}; fetch_pc<=fetch_pc+PC_STEP, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Throughput: with out_ready=1 continuously, one instruction per cycle.
- Latency: an instruction fetched at edge N appears on out_* after edge N, so it is visible during cycle N+1.
- Full queue:
  - Push is allowed only if a pop occurs in the same cycle; count is then unchanged.
  - Otherwise fetch_pc holds and inst_add is stable.
- Empty queue: out_valid=0; out_ready is ignored.
- Redirect with aligned target (any state except ERR/IDLE):
  - Queue flushed (count=0), fetch_pc<=redirect_pc.
  - No push that cycle; the word on inst_code is discarded.
  - A pop in the same cycle is also discarded: decode must not treat it as consumed, since out_valid=0 next cycle.
  - From HALT, the state stays HALT.
- Simultaneous redirect and halt_req: the redirect is applied (fetch_pc updated, flush) and the state becomes HALT.
- Count arithmetic: count is $clog2(QUEUE_DEPTH)+1 bits; pointers wrap modulo QUEUE_DEPTH.
- out_inst/out_pc are registered storage read at rd pointer; they hold their last values when out_valid=0.

Test Plan:
- Reset then stream: reset=0 for 2 cycles, out_ready=1, memory returns inst_code=inst_add^32'hA5A5_A5A5 -> first out_valid in the cycle after IDLE+1 fetch with out_pc=0; then out_pc=0,4,8,... one per cycle.
- Backpressure: out_ready=0 for 5 cycles -> count saturates at 2, inst_add holds at 8, out_pc stays 0; release -> 0,4,8 delivered in order, none lost or duplicated.
- Redirect: redirect_valid=1, redirect_pc=32'h100 while the queue holds pc 0x10 and 0x14 -> next cycle out_valid=0, inst_add=0x100; the following cycle out_pc=0x100.
- Halt: halt_req=1 with 2 entries queued, out_ready=1 -> both drain, then out_valid=0 and inst_add frozen; halt_req=0 -> fetch resumes at the frozen address.
- Misaligned target: redirect_pc=32'h102 -> fetch_misalign=1 next cycle, out_valid=0 forever; reset=0 clears fetch_misalign and restarts at RESET_PC.
- Wrap and mid-op reset: redirect to 0xFFFF_FFFC -> out_pc 0xFFFF_FFFC then 0x0; assert reset=0 while the queue is full -> next cycle out_valid=0, inst_add=RESET_PC.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch PC, instruction memory port and
// fetch queue feeding decode through a valid/ready handshake.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2,
  parameter logic [31:0] PC_STEP     = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] inst_add,
  input  logic [31:0] inst_code,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        out_ready,
  output logic        fetch_misalign
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  logic [1:0]    state_q;
  logic [1:0]    state_d;
  logic [31:0]   fetch_pc_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_next;
  logic [31:0]   q_pc   [QUEUE_DEPTH];
  logic [31:0]   q_inst [QUEUE_DEPTH];
  logic [31:0]   out_pc_q;
  logic [31:0]   out_inst_q;
  logic          misalign_q;

  logic active;
  logic redirect;
  logic bad_target;
  logic pop;
  logic push;
  logic full;
  logic head_is_push;

  assign inst_add       = fetch_pc_q;
  assign out_valid      = (count_q != '0);
  assign out_pc         = out_pc_q;
  assign out_inst       = out_inst_q;
  assign fetch_misalign = misalign_q;

  assign active     = (state_q == S_RUN) || (state_q == S_HALT);
  assign redirect   = active && redirect_valid;
  assign bad_target = redirect && (redirect_pc[1:0] != 2'b00);
  assign full       = (count_q == CW'(QUEUE_DEPTH));
  assign pop        = out_valid && out_ready && !redirect;
  assign push       = (state_q == S_RUN) && !halt_req &&
                      !redirect_valid && (!full || pop);

  assign rd_next = rd_ptr_q + PW'(pop);
  assign count_d = count_q - CW'(pop) + CW'(push);

  // An empty-after-pop queue takes its new head straight from memory.
  assign head_is_push = push && (wr_ptr_q == rd_next);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: state_d = S_RUN;
      S_RUN: begin
        if (bad_target)    state_d = S_ERR;
        else if (halt_req) state_d = S_HALT;
      end
      S_HALT: begin
        if (bad_target)     state_d = S_ERR;
        else if (redirect)  state_d = S_HALT;
        else if (!halt_req) state_d = S_RUN;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr_q]   <= inst_add;
      q_inst[wr_ptr_q] <= inst_code;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      out_pc_q   <= '0;
      out_inst_q <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bad_target) misalign_q <= 1'b1;
      if (redirect) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        if (!bad_target) fetch_pc_q <= redirect_pc;
      end else begin
        count_q  <= count_d;
        rd_ptr_q <= rd_next;
        wr_ptr_q <= wr_ptr_q + PW'(push);
        if (push) fetch_pc_q <= fetch_pc_q + PC_STEP;
        if (count_d != '0) begin
          out_pc_q   <= head_is_push ? inst_add  : q_pc[rd_next];
          out_inst_q <= head_is_push ? inst_code : q_inst[rd_next];
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: directed checks of fetch, backpressure,
// redirect, halt, misalign, wrap and mid-operation reset.
module tb_inst_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_add;
  logic [31:0] inst_code;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_ready;
  logic        fetch_misalign;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign inst_code = inst_add ^ K;

  inst_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .QUEUE_DEPTH(2),
    .PC_STEP    (32'd4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .inst_add      (inst_add),
    .inst_code     (inst_code),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .halt_req      (halt_req),
    .out_valid     (out_valid),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .out_ready     (out_ready),
    .fetch_misalign(fetch_misalign)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    out_ready = 1'b1;
    halt_req = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    tick();
    tick();
    total++;
    if (out_valid !== 1'b0 || inst_add !== 32'h0 ||
        fetch_misalign !== 1'b0) begin
      bad++;
      $display("FAIL rst_ctl got v=%b a=%h m=%b exp v=0 a=0 m=0",
               out_valid, inst_add, fetch_misalign);
    end
    total++;
    if (out_pc !== 32'h0 || out_inst !== 32'h0) begin
      bad++;
      $display("FAIL rst_out got pc=%h in=%h exp 0 0",
               out_pc, out_inst);
    end
    reset = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || inst_add !== 32'h0) begin
      bad++;
      $display("FAIL idle got v=%b a=%h exp v=0 a=0",
               out_valid, inst_add);
    end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    for (int k = 0; k < 4; k++) begin
      tick();
      e = 32'(4 * k);
      total++;
      if (out_valid !== 1'b1 || out_pc !== e ||
          out_inst !== (e ^ K)) begin
        bad++;
        $display("FAIL stream%0d got v=%b pc=%h in=%h exp pc=%h in=%h",
                 k, out_valid, out_pc, out_inst, e, e ^ K);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'hC ||
        inst_add !== 32'h14) begin
      bad++;
      $display("FAIL bp_hold got v=%b pc=%h a=%h exp v=1 pc=c a=14",
               out_valid, out_pc, inst_add);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      e = 32'h10 + 32'(4 * k);
      total++;
      if (out_valid !== 1'b1 || out_pc !== e) begin
        bad++;
        $display("FAIL bp_rel%0d got v=%b pc=%h exp pc=%h",
                 k, out_valid, out_pc, e);
      end
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || inst_add !== 32'h100 ||
        out_pc !== 32'h1C) begin
      bad++;
      $display("FAIL redir_flush got v=%b a=%h pc=%h exp v=0 a=100 pc=1c",
               out_valid, inst_add, out_pc);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h100 ||
        out_inst !== (32'h100 ^ K)) begin
      bad++;
      $display("FAIL redir_tgt got v=%b pc=%h in=%h exp pc=100",
               out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_halt();
    out_ready = 1'b0;
    tick();
    halt_req = 1'b1;
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h104 ||
        inst_add !== 32'h108) begin
      bad++;
      $display("FAIL halt_drain got v=%b pc=%h a=%h exp pc=104 a=108",
               out_valid, out_pc, inst_add);
    end
    tick();
    tick();
    total++;
    if (out_valid !== 1'b0 || inst_add !== 32'h108 ||
        out_pc !== 32'h104) begin
      bad++;
      $display("FAIL halt_empty got v=%b a=%h pc=%h exp v=0 a=108 pc=104",
               out_valid, inst_add, out_pc);
    end
    halt_req = 1'b0;
    tick();
    total++;
    if (out_valid !== 1'b0 || inst_add !== 32'h108) begin
      bad++;
      $display("FAIL halt_exit got v=%b a=%h exp v=0 a=108",
               out_valid, inst_add);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h108) begin
      bad++;
      $display("FAIL halt_resume got v=%b pc=%h exp pc=108",
               out_valid, out_pc);
    end
  endtask

  task automatic test_misalign();
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (fetch_misalign !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mis_set got m=%b v=%b exp m=1 v=0",
               fetch_misalign, out_valid);
    end
    for (int k = 0; k < 4; k++) tick();
    total++;
    if (fetch_misalign !== 1'b1 || out_valid !== 1'b0 ||
        inst_add !== 32'h10C) begin
      bad++;
      $display("FAIL mis_stick got m=%b v=%b a=%h exp m=1 v=0 a=10c",
               fetch_misalign, out_valid, inst_add);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    total++;
    if (fetch_misalign !== 1'b0 || inst_add !== 32'h0 ||
        out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mis_clr got m=%b a=%h v=%b exp m=0 a=0 v=0",
               fetch_misalign, inst_add, out_valid);
    end
    tick();
    tick();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      bad++;
      $display("FAIL mis_restart got v=%b pc=%h exp v=1 pc=0",
               out_valid, out_pc);
    end
  endtask

  task automatic test_wrap_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    total++;
    if (out_pc !== 32'hFFFF_FFFC || inst_add !== 32'h0) begin
      bad++;
      $display("FAIL wrap_top got pc=%h a=%h exp pc=fffffffc a=0",
               out_pc, inst_add);
    end
    tick();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      bad++;
      $display("FAIL wrap_zero got v=%b pc=%h exp v=1 pc=0",
               out_valid, out_pc);
    end
    out_ready = 1'b0;
    tick();
    tick();
    total++;
    if (out_valid !== 1'b1 || inst_add !== 32'h8) begin
      bad++;
      $display("FAIL wrap_full got v=%b a=%h exp v=1 a=8",
               out_valid, inst_add);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    total++;
    if (out_valid !== 1'b0 || inst_add !== 32'h0 ||
        out_pc !== 32'h0 || out_inst !== 32'h0) begin
      bad++;
      $display("FAIL midop_rst got v=%b a=%h pc=%h in=%h exp all 0",
               out_valid, inst_add, out_pc, out_inst);
    end
  endtask

  task automatic test_redirect_halt();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    halt_req = 1'b1;
    tick();
    redirect_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || inst_add !== 32'h200) begin
      bad++;
      $display("FAIL rh_apply got v=%b a=%h exp v=0 a=200",
               out_valid, inst_add);
    end
    tick();
    tick();
    total++;
    if (out_valid !== 1'b0 || inst_add !== 32'h200) begin
      bad++;
      $display("FAIL rh_halted got v=%b a=%h exp v=0 a=200",
               out_valid, inst_add);
    end
    halt_req = 1'b0;
    tick();
    tick();
    total++;
    if (out_valid !== 1'b1 || out_pc !== 32'h200) begin
      bad++;
      $display("FAIL rh_resume got v=%b pc=%h exp v=1 pc=200",
               out_valid, out_pc);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_misalign();
    test_wrap_reset();
    test_redirect_halt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
